// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and default RAM depth for the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    localparam int RAM_AW_DEF = 16;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: byte/half lane extraction with sign/zero extension and lane merge for sub-word stores
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ext_o,
    output logic [31:0] merged_o
);
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;
    logic        sgn;

    // Lane offset is already aligned to the access size, so one shift serves every size
    assign sh       = {lane_i, 3'b000};
    assign lane     = word_i >> sh;
    assign mask     = size_i == SZ_BYTE ? 32'h0000_00FF : size_i == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    assign sgn      = ~uns_i & (size_i == SZ_BYTE ? lane[7] : lane[15]);
    assign ext_o    = (lane & mask) | (~mask & {32{sgn}});
    assign merged_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
endmodule

// File: rtl/lsu.sv
// lsu: byte-addressed load/store unit in front of a word RAM; LSU_MISALIGN_CHECK_EN turns misalignment into an error
module lsu
    import lsu_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEF
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);
    state_e      state_q, state_d;
    logic        we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        mis, req_err, ram_act;
    logic [1:0]  lo;
    logic [31:0] ext, merged;

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis = (req_size_i == SZ_HALF && req_addr_i[0]) || (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif
    assign req_err = req_size_i == SZ_ILL || (|req_addr_i[31:RAM_AW+2]) || mis;
    assign lo      = req_size_i == SZ_WORD ? 2'b00 : req_size_i == SZ_HALF ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];

    lsu_lane u_lane (
        .word_i  (ram_rdata_i),
        .lane_i  (addr_q[1:0]),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .ext_o   (ext),
        .merged_o(merged)
    );

    // RAM side is decoded from registered state only
    assign ram_act     = state_q == READ || state_q == WRITE;
    assign ram_we_o    = state_q == WRITE;
    assign ram_addr_o  = ram_act ? {2'b00, addr_q[31:2]} : '0;
    assign ram_wdata_o = ram_we_o ? wdata_q : '0;
    assign req_ready_o = state_q == IDLE && reset_ni;
    assign rsp_valid_o = state_q == RESP;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o   = rsp_valid_o & err_q;

    // Next state and request/response registers; sub-word stores reuse wdata_q for the merged word
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                we_d    = req_we_i;
                uns_d   = req_unsigned_i;
                size_d  = req_size_i;
                addr_d  = {req_addr_i[31:2], lo};
                wdata_d = req_wdata_i;
                rdata_d = '0;
                err_d   = req_err;
                state_d = req_err ? RESP : (req_we_i && req_size_i == SZ_WORD) ? WRITE : READ;
            end
            READ: begin
                wdata_d = we_q ? merged : wdata_q;
                rdata_d = we_q ? '0 : ext;
                state_d = we_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: if (rsp_ready_i) begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
        endcase
    end

    // State register; async reset discards any in-flight access and response
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for lsu with a behavioural word RAM
module tb_lsu;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err, ram_we;
    logic [31:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [31:0] mem [0:65535];
    int          total = 0, bad = 0, wcnt = 0;
    logic [31:0] waddr = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu dut (
        .clk_i(clk), .reset_ni(reset_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_i(req_size), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[15:0]];

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr[15:0]] <= ram_wdata;
            wcnt  <= wcnt + 1;
            waddr <= ram_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int el,
                       input int ewr, input int stall);
        exp_t e;
        int   lat;
        int   w0;
        sb.push_back('{er, ee, el});
        w0 = wcnt;
        @(negedge clk);
        chk("ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        rsp_ready = stall == 0;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("rdata", rsp_rdata, e.rdata);
        chk("err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("ram_addr_idle", ram_addr, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 1);
            chk("hold_rdata", rsp_rdata, e.rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("writes", wcnt - w0, ewr);
        chk("b2b_ready", {31'b0, req_ready}, 1);
        chk("rsp_drop", {31'b0, rsp_valid}, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 0);
        chk("rst_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", {31'b0, rsp_err}, 0);
        chk("rst_we", {31'b0, ram_we}, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        reset_n = 1'b1;

        req(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 2, 1, 0);
        chk("w_addr", waddr, 32'h40);
        chk("w_mem", mem[16'h40], 32'hDEADBEEF);
        req(0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, 0);
        req(1, 2'b10, 0, 32'h100, 32'h11223344, 32'h0, 0, 2, 1, 0);
        req(1, 2'b00, 0, 32'h101, 32'hFFFFFF7F, 32'h0, 0, 3, 1, 0);
        chk("b_mem", mem[16'h40], 32'h11227F44);
        req(1, 2'b00, 0, 32'h103, 32'h00000080, 32'h0, 0, 3, 1, 0);
        chk("b3_mem", mem[16'h40], 32'h80227F44);
        req(0, 2'b00, 0, 32'h103, 32'h0, 32'hFFFFFF80, 0, 2, 0, 0);
        req(0, 2'b00, 1, 32'h103, 32'h0, 32'h00000080, 0, 2, 0, 0);
        req(1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 0, 3, 1, 0);
        chk("h_mem", mem[16'h40], 32'hABCD7F44);
        req(0, 2'b01, 0, 32'h102, 32'h0, 32'hFFFFABCD, 0, 2, 0, 0);
        req(0, 2'b01, 1, 32'h102, 32'h0, 32'h0000ABCD, 0, 2, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        req(0, 2'b01, 0, 32'h101, 32'h0, 32'h0, 1, 1, 0, 0);
        req(1, 2'b10, 0, 32'h105, 32'h5, 32'h0, 1, 1, 0, 0);
        chk("mis_mem", mem[16'h41], 32'h0);
`else
        req(0, 2'b01, 0, 32'h101, 32'h0, 32'h00007F44, 0, 2, 0, 0);
        req(1, 2'b10, 0, 32'h107, 32'h5, 32'h0, 0, 2, 1, 0);
        chk("mis_mem", mem[16'h41], 32'h5);
`endif
        req(0, 2'b10, 0, 32'h00040000, 32'h0, 32'h0, 1, 1, 0, 0);
        req(0, 2'b11, 0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0);
        req(1, 2'b10, 0, 32'h00040004, 32'h1, 32'h0, 1, 1, 0, 0);
        req(0, 2'b10, 0, 32'h100, 32'h0, 32'hABCD7F44, 0, 2, 0, 5);

        // Reset asserted while a byte store sits in WRITE
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h100; req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        @(negedge clk);
        chk("mid_we", {31'b0, ram_we}, 1);
        chk("mid_wdata", ram_wdata, 32'hABCD7F55);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_we_drop", {31'b0, ram_we}, 0);
        chk("rst_addr_drop", ram_addr, 0);
        chk("rst_ready_low", {31'b0, req_ready}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'b0, req_ready}, 1);
        chk("rel_valid", {31'b0, rsp_valid}, 0);
        chk("no_partial", mem[16'h40], 32'hABCD7F44);
        req(0, 2'b10, 0, 32'h100, 32'h0, 32'hABCD7F44, 0, 2, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
